// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the transmitter and the receiver.
//   UART_DATA_BITS : data bits per frame
//   ST_*           : transmit FSM state encodings
//   uart_width()   : minimum width for a counter or pointer over n values
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    // Never returns less than 1, so a 2-entry or 2-count range still gets one bit.
    function automatic int unsigned uart_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the command/status logic (master) and the UART
// transmitter (slave).
//   tx_data  : byte to transmit
//   tx_valid : tx_data is valid this cycle
//   tx_ready : transmitter can accept a byte
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read of the head entry.
//   clk, reset  : clock, synchronous active-high reset
//   push, wdata : write request and data (ignored when full)
//   pop, rdata  : read request (ignored when empty) and head entry
//   empty, full : flags derived from the registered occupancy count
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = uart_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    // Push is judged against the count at this edge: no same-cycle bypass when full.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN defined).
//   clk, reset : clock, synchronous active-high reset (aborts any frame)
//   tx_bus     : slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   uart_tx    : registered serial output, idle high
//   tx_busy    : a frame is being shifted out
//   fifo_empty : transmit FIFO holds no bytes
//   fifo_full  : transmit FIFO holds FIFO_DEPTH bytes
// Macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 26,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_fifo_if.slave        tx_bus,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 fifo_empty,
    output logic                 fifo_full
);

    localparam int unsigned BAUD_W = uart_width(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_t               state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      pop;
    logic                      bit_end;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    sync_fifo #(
        .DATA_W (UART_DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_bus.tx_valid),
        .pop   (pop),
        .wdata (tx_bus.tx_data),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign tx_bus.tx_ready = !fifo_full;
    assign tx_busy         = (state_q != ST_IDLE);
    assign uart_tx         = tx_q;
    assign bit_end         = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level follows the current state one cycle later; every bit keeps
    // its full CLKS_PER_BIT width and the output is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = ^shift_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
